// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ready handshake,
// and computes the next PC from NPCOp on consumer ack, with sticky error reporting.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ready,
    input  logic [31:0] i_imem_rdata,
    output logic [31:0] o_instr_out,
    output logic        o_instr_valid,
    input  logic        i_instr_ack,
    output logic [31:0] o_pc_out,
    output logic [31:0] o_pc_plus4,
    input  logic [2:0]  i_npc_op,
    input  logic [31:0] i_imm,
    input  logic [31:0] i_alu_out,
    output logic        o_fetch_err,
    output logic [1:0]  o_err_cause
);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_VALID, S_ERR} state_t;

    localparam int            CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TC = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    state_t        r_state;
    state_t        w_next;
    logic [31:0]   r_pc;
    logic [31:0]   r_instr;
    logic [CW-1:0] r_wait_cnt;
    logic [1:0]    r_err_cause;
    logic [31:0]   w_pc_plus4;
    logic [31:0]   w_npc;
    logic          w_timeout;
    logic          w_npc_misaligned;

    assign w_pc_plus4       = r_pc + 32'd4;
    assign w_timeout        = (TIMEOUT != 0) && (r_wait_cnt == TC);
    assign w_npc_misaligned = (w_npc[1:0] != 2'b00);

    // Non-one-hot NPCOp encodings fall back to sequential flow.
    always_comb begin
        w_npc = w_pc_plus4;
        case (i_npc_op)
            3'b001:  w_npc = r_pc + i_imm;
            3'b010:  w_npc = r_pc + i_imm;
            3'b100:  w_npc = i_alu_out & 32'hFFFF_FFFE;
            default: w_npc = w_pc_plus4;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = (RESET_PC[1:0] == 2'b00) ? S_FETCH : S_ERR;
            S_FETCH: begin
                // Ready on the terminal-count cycle still completes the fetch.
                if (i_imem_ready)   w_next = S_VALID;
                else if (w_timeout) w_next = S_ERR;
            end
            S_VALID: begin
                if (i_instr_ack) w_next = w_npc_misaligned ? S_ERR : S_FETCH;
            end
            default: w_next = S_ERR;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pc        <= RESET_PC;
            r_instr     <= 32'h0;
            r_wait_cnt  <= '0;
            r_err_cause <= 2'b00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (RESET_PC[1:0] != 2'b00) r_err_cause <= 2'b01;
                end
                S_FETCH: begin
                    if (i_imem_ready) begin
                        r_instr    <= i_imem_rdata;
                        r_wait_cnt <= '0;
                    end else if (w_timeout) begin
                        r_err_cause <= 2'b10;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                S_VALID: begin
                    if (i_instr_ack) begin
                        r_pc <= w_npc;
                        if (w_npc_misaligned) r_err_cause <= 2'b01;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_imem_req    = (r_state == S_FETCH);
    assign o_imem_addr   = r_pc;
    assign o_instr_out   = r_instr;
    assign o_instr_valid = (r_state == S_VALID);
    assign o_pc_out      = r_pc;
    assign o_pc_plus4    = w_pc_plus4;
    assign o_fetch_err   = (r_state == S_ERR);
    assign o_err_cause   = r_err_cause;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the control decoder.
- Holds the PC and issues requests to instruction memory over a req/ready handshake.
- Presents the fetched instruction word, PC and PC+4 to decode/execute. The PC+4 output feeds the WDSel_FromPC writeback path for jal.
- On consumer ack, computes the next PC from NPCOp (PLUS4/BRANCH/JUMP/JALR), the immediate and the ALU result, with misalignment and timeout error detection.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TIMEOUT, 16, max cycles in FETCH without imem_ready before error; 0 disables the timeout.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous active-high reset
- imem_req  out  1  instruction memory request
- imem_addr  out  32  fetch address (= pc_out)
- imem_ready  in  1  memory has data this cycle
- imem_rdata  in  32  instruction word, valid when imem_ready=1
- instr_out  out  32  latched instruction to decoder (Op=instr_out[6:0], Funct3=[14:12], Funct7=[31:25])
- instr_valid  out  1  instr_out/pc_out valid for consumption
- instr_ack  in  1  consumer retires current instruction, sampled only when instr_valid=1
- pc_out  out  32  PC of the current instruction
- pc_plus4  out  32  pc_out+4, combinational
- NPCOp  in  3  000 PLUS4, 001 BRANCH, 010 JUMP, 100 JALR
- imm  in  32  sign-extended immediate from EXT
- alu_out  in  32  ALU result, the jalr target
- fetch_err  out  1  sticky error flag
- err_cause  out  2  00 none, 01 misaligned target, 10 timeout

Behaviour:
- Reset (async, any state):
  - pc=RESET_PC, state=IDLE, instr_out=0.
  - imem_req=0, instr_valid=0, fetch_err=0, err_cause=00, wait counter=0.
  - Reset asserted mid-handshake abandons the request immediately.
- States: IDLE, FETCH, VALID, ERR.
- IDLE:
  - Outputs quiet.
  - Next cycle → FETCH if RESET_PC[1:0]==0, else ERR with cause 01.
- FETCH:
  - imem_req=1, imem_addr=pc, both held stable until imem_ready.
  - On imem_ready=1: instr_out<=imem_rdata, wait counter cleared, → VALID.
  - Otherwise counter increments. If TIMEOUT!=0 and counter reaches TIMEOUT-1 with no ready → ERR, cause 10.
  - Ready arriving on the same cycle the counter hits the limit wins: the fetch completes, no error.
- VALID:
  - instr_valid=1, imem_req=0; instr_out and pc_out stable.
  - Without ack, hold indefinitely (stall); no timeout in VALID.
  - On instr_ack=1, pc<=npc:
    - PLUS4: pc+4.
    - BRANCH: pc+imm.
    - JUMP: pc+imm.
    - JALR: (alu_out)&~32'h1.
    - Any other NPCOp encoding (non-one-hot): pc+4.
  - After the update: npc[1:0]!=0 → ERR, cause 01, pc still updated to npc. Else → FETCH.
- ERR:
  - fetch_err=1, imem_req=0, instr_valid=0.
  - Held until rst.
- Arithmetic: 32-bit modulo adds. 32'hFFFF_FFFC+4 wraps to 0 with no error.
- Latency:
  - imem_ready in the first FETCH cycle → instr_valid next cycle.
  - Minimum 2 cycles per instruction (1 FETCH + 1 VALID with immediate ack).
- npc is a function of the inputs sampled only on the ack edge; input changes outside VALID&&ack have no effect.
- pc_plus4 is valid in all states.

Test Plan:
- Reset release with RESET_PC=0, imem_ready=1 always, rdata=32'h00500093, instr_ack=1 → pc_out sequence 0,4,8 every 2 cycles; instr_out=32'h00500093 one cycle after each req.
- In VALID at pc=0x10: NPCOp=001, imm=32'hFFFF_FFF8, ack → next imem_addr=0x08. Repeat with NPCOp=010, imm=0x100 → 0x110.
- NPCOp=100, alu_out=32'h0000_0203, ack → pc=0x202 → ERR, err_cause=01, fetch_err=1, imem_req stays 0.
- imem_ready held low, TIMEOUT=16 → ERR after 16 FETCH cycles, err_cause=10. Separate run with ready on the 16th cycle → instruction delivered, no error.
- instr_ack low for 5 cycles in VALID → instr_out/pc_out stable, imem_req=0. Ack on cycle 6 → FETCH of pc+4.
- rst pulsed while in FETCH awaiting ready, and again while in ERR → outputs go to reset values that same cycle; fetch restarts at RESET_PC.
